// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared types and constants for the iterative restoring divider.
//   - state_e        : controller state encoding (IDLE/RUN/DONE)
//   - DIVIDEND_W_DEF : default dividend / quotient width (and iteration count)
//   - DIVISOR_W_DEF  : default divisor / remainder width
//   - cnt_width()    : iteration counter width for a given iteration count
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DIVIDEND_W_DEF = 8;
  localparam int unsigned DIVISOR_W_DEF  = 4;

  // Counter only has to hold DIVIDEND_W-1; never let it collapse to zero bits.
  function automatic int unsigned cnt_width(input int unsigned iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage : seq_divider_pkg

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
//   Request/result bundle for seq_divider.
//   Requester -> divider : start, dividend, divisor
//   Divider -> requester : busy, done, quotient, remainder, div_by_zero
//   modport master : the requester side
//   modport slave  : the divider side
// -----------------------------------------------------------------------------
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;

  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface : seq_divider_if

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring-division iteration, purely combinational.
//   Ports:
//     r_i      : partial remainder R (DIVISOR_W+1 bits)
//     q_msb_i  : MSB of the working dividend, shifted into R this step
//     d_i      : divisor D
//     r_o      : next partial remainder
//     q_bit_o  : quotient bit produced by this step
//   T = {R[DIVISOR_W-1:0], Q_msb}; if T >= D then R' = T - D, bit = 1,
//   otherwise R' = T, bit = 0.
// -----------------------------------------------------------------------------
module div_step #(
  parameter int unsigned DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   r_i,
  input  logic                 q_msb_i,
  input  logic [DIVISOR_W-1:0] d_i,
  output logic [DIVISOR_W:0]   r_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W:0]   t;
  logic [DIVISOR_W+1:0] t_wide;
  logic                 ge;

  assign t = {r_i[DIVISOR_W-1:0], q_msb_i};

  // R[DIVISOR_W] is only ever set when D is zero, where the compare is true
  // regardless; including it leaves the result identical to the T compare.
  assign t_wide = {r_i, q_msb_i};
  assign ge     = (t_wide >= {2'b00, d_i});

  always_comb begin
    r_o     = t;
    q_bit_o = 1'b0;
    if (ge) begin
      r_o     = t - {1'b0, d_i};
      q_bit_o = 1'b1;
    end
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring unsigned divider, one quotient bit per clock.
//   A start accepted in IDLE captures dividend/divisor; DIVIDEND_W iterations
//   later done pulses for one cycle with quotient/remainder registered.
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous active-high reset (dominates start)
//     bus  : seq_divider_if.slave
//            in : start, dividend, divisor
//            out: busy, done, quotient, remainder, div_by_zero
//   Build option:
//     SEQ_DIVIDER_ZERO_DETECT_EN : divisor 0 finishes IDLE->DONE in one cycle
//       and sets div_by_zero; without it divisor 0 runs the full iteration
//       count and div_by_zero is tied 0. Quotient/remainder are the same
//       (all ones, dividend[DIVISOR_W-1:0]) either way.
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned     CNT_W    = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

  state_e state_q, state_d;

  logic [DIVIDEND_W-1:0] q_q, q_d;       // working dividend / quotient shifter
  logic [DIVISOR_W:0]    r_q, r_d;       // partial remainder
  logic [DIVISOR_W-1:0]  d_q, d_d;       // captured divisor
  logic [CNT_W-1:0]      cnt_q, cnt_d;   // iterations remaining minus one

  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
  logic                  dbz_q, dbz_d;
`endif

  logic [DIVISOR_W:0]    r_step;
  logic                  q_bit;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_div_step (
    .r_i     (r_q),
    .q_msb_i (q_q[DIVIDEND_W-1]),
    .d_i     (d_q),
    .r_o     (r_step),
    .q_bit_o (q_bit)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
          state_d = (bus.divisor == '0) ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: busy/done are registered copies of the upcoming state so
  // that no input reaches an output combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d    = q_q;
    r_d    = r_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    dbz_d  = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d   = bus.dividend;
          r_d   = '0;
          d_d   = bus.divisor;
          cnt_d = CNT_LOAD;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
          // Short-circuit: publish what the full iteration would have produced.
          if (bus.divisor == '0) begin
            quot_d = '1;
            rem_d  = bus.dividend[DIVISOR_W-1:0];
            dbz_d  = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        q_d   = {q_q[DIVIDEND_W-2:0], q_bit};
        r_d   = r_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quot_d = q_d;
          rem_d  = r_step[DIVISOR_W-1:0];
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
          dbz_d  = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
      dbz_q  <= 1'b0;
`endif
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
      dbz_q  <= dbz_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed self-checking bench for seq_divider (8-bit / 4-bit).
//   Honours SEQ_DIVIDER_ZERO_DETECT_EN for divide-by-zero expectations.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  seq_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

  seq_divider #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start from a negedge with the divider idle, then follows it
  // to done. lat = edges after acceptance until done is seen (-1: timeout),
  // bcnt = sampled cycles with busy high, done_after = done one cycle later.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output int lat, output int bcnt,
                        output logic done_after);
    int k;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    k    = 0;
    lat  = -1;
    bcnt = 0;
    q    = '0;
    r    = '0;
    z    = 1'b0;
    while (k <= 20) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = k;
        q   = bus.quotient;
        r   = bus.remainder;
        z   = bus.div_by_zero;
        break;
      end
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 8'h5A;
    bus.divisor = 4'h3;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vectors++;
    if (bus.quotient !== 8'h00) begin miscompares++; $display("FAIL reset_quot got=%h exp=00", bus.quotient); end
    vectors++;
    if (bus.remainder !== 4'h0) begin miscompares++; $display("FAIL reset_rem got=%h exp=0", bus.remainder); end
    vectors++;
    if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] av[3]; logic [3:0] bv[3]; logic [7:0] eq[3]; logic [3:0] er[3];
    logic [7:0] q; logic [3:0] r; logic z, da; int lat, bcnt;
    av = '{8'd100, 8'd255, 8'd13};
    bv = '{4'd7,   4'd15,  4'd14};
    eq = '{8'd14,  8'd17,  8'd0};
    er = '{4'd2,   4'd0,   4'd13};
    for (int i = 0; i < 3; i++) begin
      do_div(av[i], bv[i], q, r, z, lat, bcnt, da);
      vectors++;
      if (q !== eq[i] || r !== er[i]) begin
        miscompares++;
        $display("FAIL basic_result %0d/%0d got q=%0d r=%0d exp q=%0d r=%0d", av[i], bv[i], q, r, eq[i], er[i]);
      end
      vectors++;
      if (lat !== 8 || bcnt !== 8 || da !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_timing %0d/%0d got lat=%0d busy=%0d done_after=%b exp lat=8 busy=8 done_after=0",
                 av[i], bv[i], lat, bcnt, da);
      end
      vectors++;
      if (z !== 1'b0) begin miscompares++; $display("FAIL basic_dbz got=%b exp=0", z); end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q; logic [3:0] r; logic z, da; int lat, bcnt;
    int exp_lat, exp_bcnt; logic exp_z;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    exp_lat = 0; exp_bcnt = 0; exp_z = 1'b1;
`else
    exp_lat = 8; exp_bcnt = 8; exp_z = 1'b0;
`endif
    do_div(8'hA5, 4'h0, q, r, z, lat, bcnt, da);
    vectors++;
    if (q !== 8'hFF || r !== 4'h5) begin
      miscompares++;
      $display("FAIL divzero_result got q=%h r=%h exp q=ff r=5", q, r);
    end
    vectors++;
    if (lat !== exp_lat || bcnt !== exp_bcnt || da !== 1'b0) begin
      miscompares++;
      $display("FAIL divzero_timing got lat=%0d busy=%0d done_after=%b exp lat=%0d busy=%0d done_after=0",
               lat, bcnt, da, exp_lat, exp_bcnt);
    end
    vectors++;
    if (z !== exp_z) begin miscompares++; $display("FAIL divzero_flag got=%b exp=%b", z, exp_z); end
    // flag must stay put between dones, then clear on the next nonzero division
    vectors++;
    if (bus.div_by_zero !== exp_z) begin miscompares++; $display("FAIL divzero_hold got=%b exp=%b", bus.div_by_zero, exp_z); end
    do_div(8'd9, 4'd2, q, r, z, lat, bcnt, da);
    vectors++;
    if (z !== 1'b0 || q !== 8'd4 || r !== 4'd1) begin
      miscompares++;
      $display("FAIL divzero_clear got dbz=%b q=%0d r=%0d exp dbz=0 q=4 r=1", z, q, r);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt, first_done, second_done;
    logic busy9, busy10, busy20;
    bus.dividend = 8'd42;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    done_cnt = 0; first_done = -1; second_done = -1;
    busy9 = 1'bx; busy10 = 1'bx; busy20 = 1'bx;
    @(posedge clk);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 19) bus.start = 1'b0;
      if (k == 9)  busy9  = bus.busy;
      if (k == 10) busy10 = bus.busy;
      if (k == 20) busy20 = bus.busy;
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) first_done = k; else second_done = k;
        vectors++;
        if (bus.quotient !== 8'd8 || bus.remainder !== 4'd2) begin
          miscompares++;
          $display("FAIL b2b_result at k=%0d got q=%0d r=%0d exp q=8 r=2", k, bus.quotient, bus.remainder);
        end
      end
    end
    vectors++;
    if (done_cnt !== 2 || first_done !== 8 || second_done !== 18) begin
      miscompares++;
      $display("FAIL b2b_dones got count=%0d at %0d,%0d exp count=2 at 8,18", done_cnt, first_done, second_done);
    end
    vectors++;
    if (busy9 !== 1'b0 || busy10 !== 1'b1 || busy20 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_busy got k9=%b k10=%b k20=%b exp 0 1 0", busy9, busy10, busy20);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q; logic [3:0] r; logic z, da; int lat, bcnt;
    logic saw_done;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'h00 ||
        bus.remainder !== 4'h0 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs got busy=%b done=%b q=%h r=%h dbz=%b exp all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin miscompares++; $display("FAIL midreset_quiet got activity=1 exp=0"); end
    do_div(8'd200, 4'd3, q, r, z, lat, bcnt, da);
    vectors++;
    if (q !== 8'd66 || r !== 4'd2 || lat !== 8) begin
      miscompares++;
      $display("FAIL midreset_rerun got q=%0d r=%0d lat=%0d exp q=66 r=2 lat=8", q, r, lat);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] q; logic [3:0] r; logic z, da; int lat, bcnt;
    int eq, er;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(8'(a), 4'(b), q, r, z, lat, bcnt, da);
        eq = a / b;
        er = a % b;
        vectors++;
        if (int'(q) !== eq || int'(r) !== er || (int'(q) * b + int'(r)) != a || int'(r) >= b || lat !== 8) begin
          miscompares++;
          $display("FAIL exhaustive %0d/%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=8", a, b, q, r, lat, eq, er);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_seq_divider
